state_unmix: RTL and testbench
==============================

Name: state_unmix

Overview:
- Decoder counterpart of the team's state-mixing engine.
- Accepts an 8 x 32-bit mixed state vector as a word stream, applies the exact inverse of ROUNDS mixing rounds with one word operation per cycle, and streams out the recovered 8-word state.
- Sits downstream of the mixer in self-check and scramble/unscramble paths.

Parameters:
ROUNDS, 1, number of forward rounds to undo; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word present
in_ready  output  1  block can accept an input word
in_data  input  32  input word; beat k carries w[k], k = 0..7
out_valid  output  1  output word present
out_ready  input  1  sink accepts the output word
out_data  output  32  output word; beat k carries recovered w[k]
busy  output  1  high in ROUND and DRAIN

Behaviour:
- Reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
  - Values while asserted: in_ready=0, out_valid=0, out_data=0, busy=0; all 8 words, counters and state cleared.
  - After reset: first cycle is LOAD with in_ready=1.
  - Assertion mid-operation aborts the block immediately; partial data is discarded.
- Forward mix being inverted. Each round runs stages A, B, C in that order. Indices are mod 8; each step uses the current values (sequential update).
  - A: for i=0..7, w[i] = w[i] + w[i-1].
  - B: for i=0..7, w[i] = w[i] ^ (w[i+3] << 16).
  - C: for i=0..7, w[i] = w[i] * K[i], with K = {3,5,7,11,13,17,19,23}.
  - All arithmetic is 32-bit, wrap-around, unsigned; shift results are truncated to 32 bits.
- Inverse per round, done ROUNDS times:
  - C': for i=0..7, w[i] = w[i] * KI[i], where KI[i]*K[i] = 1 mod 2^32. KI are hard constants, e.g. KI[0] = 32'hAAAAAAAB.
  - B': for i=7 down to 0, w[i] = w[i] ^ (w[i+3] << 16).
  - A': for i=7 down to 0, w[i] = w[i] - w[i-1].
- State machine:
  - LOAD:
    - in_ready=1. Each in_valid && in_ready stores in_data into w[idx], then idx++.
    - When the 8th word is accepted, go to ROUND with stage=C', step=0, round=0.
  - ROUND:
    - in_ready=0, out_valid=0.
    - Exactly one word operation per cycle: 8 cycles per stage, 24 per round.
    - After 24*ROUNDS cycles, go to DRAIN with idx=0.
  - DRAIN:
    - out_valid=1 and out_data=w[idx].
    - On out_ready, idx++. out_data is held stable while out_valid && !out_ready.
    - After the 8th accepted word, go to LOAD; in_ready=1 on the next cycle.
- Latency: with the last input accepted at edge T, out_valid first rises in the cycle after edge T+24*ROUNDS.
- Boundary conditions:
  - in_valid is ignored outside LOAD.
  - No overlap between blocks: input is not accepted during DRAIN.
  - in_valid gaps inside LOAD just stall idx.
  - out_ready gaps in DRAIN stall idx.
- Throughput: one block per 16 + 24*ROUNDS cycles at minimum.

Optional Feature:
- Macro: STATE_UNMIX_BLKCNT_EN.
- Defined: adds output port blk_cnt [15:0].
  - Reset value 0.
  - Increments on acceptance of the 8th output word.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset/idle: hold rst_n=0 5 cycles, then release -> in_ready=1, out_valid=0, busy=0, out_data=0.
- Zero vector, ROUNDS=1: feed 8 x 32'h0 -> exactly 24 ROUND cycles -> out_data 8 x 32'h0; in_ready returns to 1 after the 8th output.
- Known vector, ROUNDS=1:
  - Input: feed 32'h00030003, 00050005, 00070007, 000B000B, 000D000D, 00110011, 00130013, 00170017.
  - Required output: 32'h1, 0, 0, 0, 0, 0, 0, 0.
  - Required timing: out_valid first rises in the cycle after edge T+24.
- Round-trip, ROUNDS=3: 200 random vectors forward-mixed by the reference model, with random in_valid/out_ready gaps -> each output equals the original vector; out_data is stable during stalls.
- Reset mid-ROUND: assert rst_n=0 at ROUND cycle 10 -> outputs clear immediately; the next full block decodes correctly.
- STATE_UNMIX_BLKCNT_EN defined: decode 3 blocks -> blk_cnt = 3; force the counter to 16'hFFFF, decode 1 block -> blk_cnt stays at 16'hFFFF.

Source files
------------

// File: rtl/state_unmix_if.sv
// Word-stream handshake bundle for state_unmix: load side, drain side and busy flag.
interface state_unmix_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/state_unmix.sv
// state_unmix: undoes ROUNDS rounds of the 8x32 state mixer, one word operation per cycle.
// Macro STATE_UNMIX_BLKCNT_EN adds a saturating blk_cnt output counting completed blocks.
module state_unmix #(
  parameter int unsigned ROUNDS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  state_unmix_if.slave bus
`ifdef STATE_UNMIX_BLKCNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  typedef enum logic [1:0] {S_LOAD, S_ROUND, S_DRAIN} state_t;
  typedef enum logic [1:0] {G_C, G_B, G_A} stage_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_t      r_state;
  stage_t      r_stage;
  logic [2:0]  r_idx;
  logic [3:0]  r_round;
  logic [31:0] r_w [8];
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_busy;

  logic [2:0]  w_tgt;
  logic [31:0] w_res;

  // Multiplicative inverses of the mixer constants {3,5,7,11,13,17,19,23} mod 2^32.
  function automatic logic [31:0] ki(input logic [2:0] i);
    case (i)
      3'd0:    ki = 32'hAAAAAAAB;
      3'd1:    ki = 32'hCCCCCCCD;
      3'd2:    ki = 32'hB6DB6DB7;
      3'd3:    ki = 32'hBA2E8BA3;
      3'd4:    ki = 32'hC4EC4EC5;
      3'd5:    ki = 32'hF0F0F0F1;
      3'd6:    ki = 32'h286BCA1B;
      default: ki = 32'hE9BD37A7;
    endcase
  endfunction

  // The xor and subtract stages must walk the words in reverse to undo sequential updates.
  always_comb begin
    w_tgt = (r_stage == G_C) ? r_idx : 3'd7 - r_idx;
    w_res = r_w[w_tgt];
    case (r_stage)
      G_C:     w_res = r_w[w_tgt] * ki(w_tgt);
      G_B:     w_res = r_w[w_tgt] ^ (r_w[w_tgt + 3'd3] << 16);
      default: w_res = r_w[w_tgt] - r_w[w_tgt - 3'd1];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_stage     <= G_C;
      r_idx       <= 3'd0;
      r_round     <= 4'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < 8; i++) r_w[i] <= 32'd0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_in_ready <= 1'b1;
          if (bus.in_valid && r_in_ready) begin
            r_w[r_idx] <= bus.in_data;
            r_idx      <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state    <= S_ROUND;
              r_stage    <= G_C;
              r_round    <= 4'd0;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        S_ROUND: begin
          r_w[w_tgt] <= w_res;
          r_idx      <= r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            case (r_stage)
              G_C:     r_stage <= G_B;
              G_B:     r_stage <= G_A;
              default: begin
                r_stage <= G_C;
                if (r_round == LAST_ROUND) begin
                  r_state     <= S_DRAIN;
                  r_out_valid <= 1'b1;
                end else begin
                  r_round <= r_round + 4'd1;
                end
              end
            endcase
          end
        end
        default: begin
          if (bus.out_ready) begin
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state     <= S_LOAD;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_valid ? r_w[r_idx] : 32'd0;
  assign bus.busy      = r_busy;

`ifdef STATE_UNMIX_BLKCNT_EN
  logic r_dummy_unused;
  logic [15:0] r_blk_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt <= 16'd0;
    end else if (r_state == S_DRAIN && bus.out_ready && r_idx == 3'd7 &&
                 r_blk_cnt != 16'hFFFF) begin
      r_blk_cnt <= r_blk_cnt + 16'd1;
    end
  end
  assign r_dummy_unused = 1'b0;
  assign blk_cnt = r_blk_cnt;
`endif

endmodule

// File: tb/tb_state_unmix.sv
// Bench for state_unmix: ROUNDS=1 and ROUNDS=3 instances checked against a forward-mix model.
`timescale 1ns/1ps
module tb_state_unmix;
  typedef logic [7:0][31:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid [2];
  logic [31:0] in_data [2];
  logic        out_ready [2];
  logic        in_ready [2];
  logic        out_valid [2];
  logic [31:0] out_data [2];
  logic        busy [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  int   rdy_pct [2];
  int   ob [2];
  int   t_acc [2];
  logic prev_ov [2];
  logic prev_stall [2];
  logic [31:0] prev_data [2];
  vec_t exp_q [2][$];

  state_unmix_if if_r1 ();
  state_unmix_if if_r3 ();

  assign if_r1.in_valid  = in_valid[0];
  assign if_r1.in_data   = in_data[0];
  assign if_r1.out_ready = out_ready[0];
  assign in_ready[0]     = if_r1.in_ready;
  assign out_valid[0]    = if_r1.out_valid;
  assign out_data[0]     = if_r1.out_data;
  assign busy[0]         = if_r1.busy;
  assign if_r3.in_valid  = in_valid[1];
  assign if_r3.in_data   = in_data[1];
  assign if_r3.out_ready = out_ready[1];
  assign in_ready[1]     = if_r3.in_ready;
  assign out_valid[1]    = if_r3.out_valid;
  assign out_data[1]     = if_r3.out_data;
  assign busy[1]         = if_r3.busy;

`ifdef STATE_UNMIX_BLKCNT_EN
  logic [15:0] blk_cnt [2];
`endif

  state_unmix #(.ROUNDS(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .bus(if_r1)
`ifdef STATE_UNMIX_BLKCNT_EN
    , .blk_cnt(blk_cnt[0])
`endif
  );

  state_unmix #(.ROUNDS(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .bus(if_r3)
`ifdef STATE_UNMIX_BLKCNT_EN
    , .blk_cnt(blk_cnt[1])
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // Forward mixer written straight from the round definition; the DUT must undo it.
  function automatic vec_t fwd_mix(input vec_t v, input int rounds);
    vec_t w;
    int unsigned k [8];
    k = '{3, 5, 7, 11, 13, 17, 19, 23};
    w = v;
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i < 8; i++) w[i] = w[i] + w[(i + 7) % 8];
      for (int i = 0; i < 8; i++) w[i] = w[i] ^ (w[(i + 3) % 8] << 16);
      for (int i = 0; i < 8; i++) w[i] = w[i] * k[i];
    end
    return w;
  endfunction

  task automatic check(input string nm, input int u, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s (ROUNDS=%0d): actual %h required %h", nm, rnd(u), act, req);
    end
  endtask

  task automatic send(input int u, input vec_t v, input int gap_pct);
    int k = 0;
    int guard = 0;
    while (k < 8 && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (!in_ready[u]) begin
        in_valid[u] = 1'($urandom_range(1));
        in_data[u]  = $urandom;
      end else if (int'($urandom_range(99)) < gap_pct) begin
        in_valid[u] = 1'b0;
        in_data[u]  = $urandom;
      end else begin
        in_valid[u] = 1'b1;
        in_data[u]  = v[k];
        k++;
      end
    end
    if (k < 8) check("send_timeout", u, 32'(k), 32'd8);
    @(negedge clk);
    in_valid[u] = 1'b0;
    t_acc[u] = cyc;
  endtask

  task automatic wait_drain(input int u);
    int guard = 0;
    while (exp_q[u].size() != 0 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q[u].size() != 0) check("drain_timeout", u, 32'(exp_q[u].size()), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    repeat (cycles) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_in_ready", u, 32'(in_ready[u]), 32'd0);
      check("rst_out_valid", u, 32'(out_valid[u]), 32'd0);
      check("rst_busy", u, 32'(busy[u]), 32'd0);
      check("rst_out_data", u, out_data[u], 32'd0);
      exp_q[u].delete();
      ob[u] = 0;
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("idle_in_ready", u, 32'(in_ready[u]), 32'd1);
      check("idle_out_valid", u, 32'(out_valid[u]), 32'd0);
      check("idle_busy", u, 32'(busy[u]), 32'd0);
      check("idle_out_data", u, out_data[u], 32'd0);
    end
    chk_en = 1'b1;
  endtask

  // Sink: out_ready changes just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) out_ready[u] = (int'($urandom_range(99)) < rdy_pct[u]);
    end
  end

  // Compare process: data order, hold-while-stalled, handshake invariants, first-output latency.
  initial begin
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (!rst_n || !chk_en) begin
          prev_stall[u] = 1'b0;
          prev_ov[u]    = 1'b0;
        end else begin
          if (prev_stall[u]) begin
            check("hold_valid", u, 32'(out_valid[u]), 32'd1);
            check("hold_data", u, out_data[u], prev_data[u]);
          end
          check("busy_eq_not_ready", u, 32'(busy[u]), 32'(!in_ready[u]));
          check("ready_and_valid", u, 32'(in_ready[u] & out_valid[u]), 32'd0);
          if (out_valid[u] && !prev_ov[u])
            check("latency", u, 32'(cyc - t_acc[u]), 32'(24 * rnd(u)));
          if (out_valid[u] && out_ready[u]) begin
            if (exp_q[u].size() == 0) begin
              check("unexpected_output", u, 32'd1, 32'd0);
            end else begin
              check("out_data", u, out_data[u], exp_q[u][0][ob[u]]);
              ob[u]++;
              if (ob[u] == 8) begin
                void'(exp_q[u].pop_front());
                ob[u] = 0;
              end
            end
          end
          prev_stall[u] = out_valid[u] && !out_ready[u];
          prev_ov[u]    = out_valid[u];
          prev_data[u]  = out_data[u];
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t one_v, known, v, m;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; in_data[u] = 32'd0; out_ready[u] = 1'b0;
      rdy_pct[u] = 100; ob[u] = 0; t_acc[u] = 0;
    end
    one_v = '0;
    one_v[0] = 32'h1;
    known = {32'h00170017, 32'h00130013, 32'h00110011, 32'h000D000D,
             32'h000B000B, 32'h00070007, 32'h00050005, 32'h00030003};

    m = fwd_mix(one_v, 1);
    for (int i = 0; i < 8; i++) check("model_pin", 0, m[i], known[i]);

    do_reset(5);

    // Zero vector, then in_ready must come back right after the 8th output.
    exp_q[0].push_back('0);
    send(0, '0, 0);
    wait_drain(0);
    @(posedge clk); #1;
    check("ready_after_drain", 0, 32'(in_ready[0]), 32'd1);

    // Known vector with the literal expectation.
    exp_q[0].push_back(one_v);
    send(0, known, 0);
    wait_drain(0);

    rdy_pct[0] = 60;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 8; i++) v[i] = $urandom;
      exp_q[0].push_back(v);
      send(0, fwd_mix(v, 1), 30);
    end
    wait_drain(0);

    rdy_pct[1] = 60;
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 8; i++) v[i] = $urandom;
      exp_q[1].push_back(v);
      send(1, fwd_mix(v, 3), 30);
    end
    wait_drain(1);

    // Abort mid-ROUND, then a full block must still decode.
    for (int i = 0; i < 8; i++) v[i] = $urandom;
    send(1, fwd_mix(v, 3), 0);
    repeat (10) @(negedge clk);
    check("busy_in_round", 1, 32'(busy[1]), 32'd1);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("abort_in_ready", 1, 32'(in_ready[1]), 32'd0);
    check("abort_out_valid", 1, 32'(out_valid[1]), 32'd0);
    check("abort_busy", 1, 32'(busy[1]), 32'd0);
    check("abort_out_data", 1, out_data[1], 32'd0);
    do_reset(3);
    for (int i = 0; i < 8; i++) v[i] = $urandom;
    exp_q[1].push_back(v);
    send(1, fwd_mix(v, 3), 20);
    wait_drain(1);

`ifdef STATE_UNMIX_BLKCNT_EN
    do_reset(3);
    check("blk_cnt_reset", 0, 32'(blk_cnt[0]), 32'd0);
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 8; i++) v[i] = $urandom;
      exp_q[0].push_back(v);
      send(0, fwd_mix(v, 1), 20);
    end
    wait_drain(0);
    @(posedge clk); #1;
    check("blk_cnt_three", 0, 32'(blk_cnt[0]), 32'd3);
    force u_d1.r_blk_cnt = 16'hFFFF;
    @(negedge clk);
    release u_d1.r_blk_cnt;
    for (int i = 0; i < 8; i++) v[i] = $urandom;
    exp_q[0].push_back(v);
    send(0, fwd_mix(v, 1), 0);
    wait_drain(0);
    @(posedge clk); #1;
    check("blk_cnt_saturate", 0, 32'(blk_cnt[0]), 32'h0000FFFF);
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
